mdu: RTL

Multiply/divide unit in the EX stage beside the combinational `alu`. It consumes the same 32-bit operands `A`/`B` and executes MIPS mult/multu/div/divu/mthi/mtlo into dedicated HI/LO registers. It is a fixed-latency multi-cycle unit that raises `busy` so the hazard unit stalls any later MDU instruction. HI/LO are always readable for mfhi/mflo.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_divcore.sv | 44 ++++
 rtl/mdu.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - MDUOp encodings (3 bits)
//   - FSM state encoding
//   - default multiply/divide latencies
package mdu_pkg;

  localparam logic [2:0] MDU_NOP   = 3'b000;
  localparam logic [2:0] MDU_MULT  = 3'b001;
  localparam logic [2:0] MDU_MULTU = 3'b010;
  localparam logic [2:0] MDU_DIV   = 3'b011;
  localparam logic [2:0] MDU_DIVU  = 3'b100;
  localparam logic [2:0] MDU_MTHI  = 3'b101;
  localparam logic [2:0] MDU_MTLO  = 3'b110;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_divcore.sv
// mdu_divcore: combinational 32-bit divide, signed or unsigned.
//   a_i, b_i   : dividend / divisor
//   signed_i   : 1 = signed (quotient truncated toward zero, remainder takes sign of a_i)
//   quot_o     : quotient  (goes to LO)
//   rem_o      : remainder (goes to HI)
// Divide by zero yields quot=all ones, rem=a_i regardless of signedness.
// The signed overflow case 0x8000_0000 / -1 yields quot=0x8000_0000, rem=0.
module mdu_divcore (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        signed_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  logic        neg_a, neg_b;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;

  // Signed divide is done on magnitudes, signs are restored afterwards.
  assign neg_a = signed_i & a_i[31];
  assign neg_b = signed_i & b_i[31];
  assign a_mag = neg_a ? (32'd0 - a_i) : a_i;
  assign b_mag = neg_b ? (32'd0 - b_i) : b_i;

  always_comb begin
    q_mag  = 32'd0;
    r_mag  = 32'd0;
    quot_o = 32'd0;
    rem_o  = 32'd0;
    if (b_i == 32'd0) begin
      quot_o = 32'hFFFF_FFFF;
      rem_o  = a_i;
    end else if (signed_i && a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
      quot_o = 32'h8000_0000;
      rem_o  = 32'd0;
    end else begin
      q_mag  = a_mag / b_mag;
      r_mag  = a_mag % b_mag;
      quot_o = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
      rem_o  = neg_a ? (32'd0 - r_mag) : r_mag;
    end
  end

endmodule

// File: rtl/mdu.sv
// mdu: fixed-latency multiply/divide unit with HI/LO registers.
//   clk, rst_n : clock, asynchronous active-low reset
//   A, B       : operands (sampled at accept)
//   MDUOp      : operation select (see mdu_pkg)
//   start      : request, accepted when idle and op is not NOP/reserved
//   busy       : MUL/DIV operation in flight
//   done       : one-cycle pulse after HI/LO commit
//   HI, LO     : architectural HI/LO registers
//
// state  | meaning
// S_IDLE | ready; MTHI/MTLO complete here in one edge
// S_MUL  | multiply result held in shadow regs, counting down to commit
// S_DIV  | divide result held in shadow regs, counting down to commit
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic        done_q, done_d;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] quot, rem;

  assign prod_s = $signed(A) * $signed(B);
  assign prod_u = {32'd0, A} * {32'd0, B};

  mdu_divcore u_divcore (
    .a_i      (A),
    .b_i      (B),
    .signed_i (MDUOp == MDU_DIV),
    .quot_o   (quot),
    .rem_o    (rem)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (MDUOp)
            MDU_MULT: begin
              {res_hi_d, res_lo_d} = prod_s;
              cnt_d   = 4'(MULT_CYCLES - 1);
              state_d = S_MUL;
            end
            MDU_MULTU: begin
              {res_hi_d, res_lo_d} = prod_u;
              cnt_d   = 4'(MULT_CYCLES - 1);
              state_d = S_MUL;
            end
            MDU_DIV, MDU_DIVU: begin
              res_hi_d = rem;
              res_lo_d = quot;
              cnt_d    = 4'(DIV_CYCLES - 1);
              state_d  = S_DIV;
            end
            MDU_MTHI: hi_d = A;
            MDU_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        // Counter reaching zero marks the commit edge; busy drops with it.
        if (cnt_q == 4'd0) begin
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
